// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the pipelined MIPS CPU. Owns the program counter,
// presents it to instruction memory, and registers the returned word into the
// IF/ID pipeline register for the decode stage.
//
// Control flow resolves in ID, and ID redirects this stage. There is no branch
// delay slot, so a redirect squashes the one instruction already fetched and
// leaves a single bubble in IF/ID. The hazard unit freezes the stage on
// load-use hazards.
//
// Ports
//   clock            rising-edge clock for all state
//   reset            synchronous, active-low
//   stall            hold PC and IF/ID (wins over redirect)
//   redirect_valid   ID-stage control-flow change
//   redirect_target  new PC, bits [1:0] ignored
//   im_rdata         instruction word at im_addr (combinational memory read)
//   im_addr          instruction-memory byte address, equal to pc
//   pc               current fetch PC
//   if_id_instr      registered instruction for ID
//   if_id_pc4        registered fetch PC + 4 (jal link value)
//   if_id_valid      IF/ID holds a real instruction
//   fetch_count      instructions delivered to IF/ID
//   flush_count      instructions squashed by redirect
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] im_rdata,
  output logic [31:0] im_addr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
);

  // Encoding of what the stage does on the coming edge (reset is handled
  // directly in the sequential block because it overrides everything).
  localparam logic [1:0] ACT_NORMAL   = 2'd0;
  localparam logic [1:0] ACT_STALL    = 2'd1;
  localparam logic [1:0] ACT_REDIRECT = 2'd2;

  logic [1:0]  action;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;

  logic [31:0] pc_next;
  logic [31:0] instr_next;
  logic [31:0] pc4_next;
  logic        valid_next;
  logic [31:0] fetch_count_next;
  logic [31:0] flush_count_next;

  // Modulo-2^32 arithmetic: 0xFFFF_FFFC + 4 wraps to 0 naturally.
  assign pc_plus4       = pc + 32'd4;
  assign target_aligned = {redirect_target[31:2], 2'b00};
  assign im_addr        = pc;

  // Stall has priority over redirect: the ID instruction asking for the
  // redirect (e.g. a jr waiting on a load) is itself not yet resolved.
  always_comb begin
    if (stall)               action = ACT_STALL;
    else if (redirect_valid) action = ACT_REDIRECT;
    else                     action = ACT_NORMAL;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    pc_next          = pc;
    instr_next       = if_id_instr;
    pc4_next         = if_id_pc4;
    valid_next       = if_id_valid;
    fetch_count_next = fetch_count;
    flush_count_next = flush_count;

    case (action)
      ACT_REDIRECT: begin
        // Squash the word fetched this cycle and insert a nop bubble.
        pc_next          = target_aligned;
        instr_next       = 32'h0000_0000;
        pc4_next         = 32'h0000_0000;
        valid_next       = 1'b0;
        flush_count_next = flush_count + 32'd1;
      end
      ACT_NORMAL: begin
        pc_next          = pc_plus4;
        instr_next       = im_rdata;
        pc4_next         = pc_plus4;
        valid_next       = 1'b1;
        fetch_count_next = fetch_count + 32'd1;
      end
      default: ; // ACT_STALL: everything holds
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      pc          <= PC_RESET;
      if_id_instr <= 32'h0000_0000;
      if_id_pc4   <= 32'h0000_0000;
      if_id_valid <= 1'b0;
      fetch_count <= 32'h0000_0000;
      flush_count <= 32'h0000_0000;
    end else begin
      pc          <= pc_next;
      if_id_instr <= instr_next;
      if_id_pc4   <= pc4_next;
      if_id_valid <= valid_next;
      fetch_count <= fetch_count_next;
      flush_count <= flush_count_next;
    end
  end

endmodule
